// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the instruction-fetch
// and load/store ports; every output is registered and each grant runs IDLE -> BUSY -> RELEASE.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_dm_rd,
  input  logic              i_dm_wr,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rden,
  output logic              o_mem_wren,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_response,
  output logic              o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t            r_state, w_stateNext;
  logic              r_lastGrantDm, w_lastGrantDmNext;
  logic              r_grantDm, w_grantDmNext;
  logic [TW-1:0]     r_timer, w_timerNext;
  logic [ADDR_W-1:0] r_memAddr, w_memAddrNext;
  logic [DATA_W-1:0] r_memWdata, w_memWdataNext;
  logic              r_memRden, w_memRdenNext;
  logic              r_memWren, w_memWrenNext;
  logic [DATA_W-1:0] r_ifRdata, w_ifRdataNext;
  logic [DATA_W-1:0] r_dmRdata, w_dmRdataNext;
  logic              r_ifAck, w_ifAckNext;
  logic              r_dmAck, w_dmAckNext;
  logic              r_err, w_errNext;

  logic w_ifPend, w_dmPend, w_pickDm;

  assign w_ifPend = i_if_req;
  assign w_dmPend = i_dm_rd | i_dm_wr;
  // With both ports pending, the port that did not win last time goes first.
  assign w_pickDm = w_dmPend & (~w_ifPend | ~r_lastGrantDm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_lastGrantDm <= 1'b0;
      r_grantDm     <= 1'b0;
      r_timer       <= '0;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_memRden     <= 1'b0;
      r_memWren     <= 1'b0;
      r_ifRdata     <= '0;
      r_dmRdata     <= '0;
      r_ifAck       <= 1'b0;
      r_dmAck       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_lastGrantDm <= w_lastGrantDmNext;
      r_grantDm     <= w_grantDmNext;
      r_timer       <= w_timerNext;
      r_memAddr     <= w_memAddrNext;
      r_memWdata    <= w_memWdataNext;
      r_memRden     <= w_memRdenNext;
      r_memWren     <= w_memWrenNext;
      r_ifRdata     <= w_ifRdataNext;
      r_dmRdata     <= w_dmRdataNext;
      r_ifAck       <= w_ifAckNext;
      r_dmAck       <= w_dmAckNext;
      r_err         <= w_errNext;
    end
  end

  always_comb begin
    w_stateNext       = r_state;
    w_lastGrantDmNext = r_lastGrantDm;
    w_grantDmNext     = r_grantDm;
    w_timerNext       = r_timer;
    w_memAddrNext     = r_memAddr;
    w_memWdataNext    = r_memWdata;
    w_memRdenNext     = r_memRden;
    w_memWrenNext     = r_memWren;
    w_ifRdataNext     = r_ifRdata;
    w_dmRdataNext     = r_dmRdata;
    w_ifAckNext       = 1'b0;
    w_dmAckNext       = 1'b0;
    w_errNext         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ifPend || w_dmPend) begin
          w_grantDmNext     = w_pickDm;
          w_lastGrantDmNext = w_pickDm;
          w_timerNext       = '0;
          w_stateNext       = BUSY;
          if (w_pickDm) begin
            w_memAddrNext  = i_dm_addr;
            w_memWrenNext  = i_dm_wr;
            w_memRdenNext  = ~i_dm_wr;
            w_memWdataNext = i_dm_wr ? i_dm_wdata : '0;
          end else begin
            w_memAddrNext  = i_if_addr;
            w_memRdenNext  = 1'b1;
            w_memWrenNext  = 1'b0;
            w_memWdataNext = '0;
          end
        end
      end
      BUSY: begin
        if (i_mem_response) begin
          w_memRdenNext = 1'b0;
          w_memWrenNext = 1'b0;
          w_stateNext   = RELEASE;
          if (r_grantDm) begin
            w_dmAckNext   = 1'b1;
            w_dmRdataNext = r_memRden ? i_mem_rdata : '0;
          end else begin
            w_ifAckNext   = 1'b1;
            w_ifRdataNext = i_mem_rdata;
          end
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          // Memory never answered: abort with an error-flagged ack and zero data.
          w_memRdenNext = 1'b0;
          w_memWrenNext = 1'b0;
          w_errNext     = 1'b1;
          w_stateNext   = RELEASE;
          if (r_grantDm) begin
            w_dmAckNext   = 1'b1;
            w_dmRdataNext = '0;
          end else begin
            w_ifAckNext   = 1'b1;
            w_ifRdataNext = '0;
          end
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end
      RELEASE: begin
        if (!i_mem_response) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_if_rdata  = r_ifRdata;
  assign o_if_ack    = r_ifAck;
  assign o_dm_rdata  = r_dmRdata;
  assign o_dm_ack    = r_dmAck;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_rden  = r_memRden;
  assign o_mem_wren  = r_memWren;
  assign o_mem_wdata = r_memWdata;
  assign o_err       = r_err;

endmodule
